spi_slave_frame_ctrl: RTL and testbench
=======================================

SPI_SLAVE_FRAME_CTRL -- requirements
Module: spi_slave_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per SPI word (legal 4..32).
REQ-002 Parameter TX_FILL, default 1'b1, bit replicated across a word transmitted on TX underrun.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_sclk  input  1  asynchronous SPI clock pin, mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_cs_n  input  1  asynchronous chip select, active-low.
REQ-007 spi_mosi  input  1  asynchronous serial data in, MSB first.
REQ-008 spi_miso  output  1  serial data out, MSB first, registered.
REQ-009 rx_data  output  DATA_WIDTH  last received word.
REQ-010 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-011 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-012 rx_overrun  output  1  one-cycle pulse: word completed while rx_valid was still pending.
REQ-013 tx_data  input  DATA_WIDTH  next word to transmit.
REQ-014 tx_valid  input  1  tx_data offered.
REQ-015 tx_ready  output  1  TX buffer empty; load occurs on tx_valid && tx_ready.
REQ-016 tx_underrun  output  1  one-cycle pulse: word start found TX buffer empty.
REQ-017 frame_active  output  1  high while FSM is in ACTIVE.
REQ-018 frame_abort  output  1  one-cycle pulse: cs_n deasserted with 1..DATA_WIDTH-1 bits of a word received.

Function
REQ-019 spi_sclk, spi_cs_n, spi_mosi each pass through a 2-flop synchronizer plus one history flop; edge events are sync_out && !hist (rise) and !sync_out && hist (fall).
REQ-020 A pin transition produces its edge event exactly 3 clk cycles later; MOSI is sampled from the synchronizer output in the same cycle as the aligned sclk rise event.
REQ-021 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on cs_n fall event; ACTIVE->IDLE on cs_n rise event; no other transitions.
REQ-022 In IDLE, sclk events are ignored and the bit counter is held at 0.
REQ-023 In ACTIVE, each sclk rise event shifts sampled MOSI into the RX shift register LSB side and increments the bit counter.
REQ-024 On the DATA_WIDTH-th rise event the counter wraps to 0 and the word completes; the next clk cycle rx_data is updated and rx_valid is set, unless an overrun applies.
REQ-025 If a word completes while rx_valid=1 and rx_ready=0 in that cycle, rx_data is unchanged, the new word is dropped, and rx_overrun pulses the following cycle.
REQ-026 rx_valid clears the cycle after rx_valid && rx_ready; completion and acceptance in the same cycle is not an overrun.
REQ-027 Word start occurs on the cs_n fall event and on each counter wrap; at word start the TX shift register loads the TX buffer (buffer then empties) or, if empty, {DATA_WIDTH{TX_FILL}} with tx_underrun pulsed.
REQ-028 spi_miso is driven with the TX shift register MSB in the cycle after word start; the register shifts left on each sclk fall event in ACTIVE, except the fall immediately following a wrap.
REQ-029 tx_ready = !buffer_full; a tx load and a word-start consume never coincide because the load is gated by tx_ready.
REQ-030 A cs_n rise event coincident with an sclk event takes priority; the sclk event is discarded.
REQ-031 On cs_n rise with bit counter nonzero: partial word discarded, frame_abort pulses next cycle, counter cleared; a TX word already loaded is lost and the TX buffer is unaffected.
REQ-032 In IDLE spi_miso holds the last driven value.

Reset
REQ-033 With rst high at a clk edge: FSM=IDLE, counter=0, synchronizer/history flops for sclk=0, cs_n=1, mosi=0.
REQ-034 Reset outputs: spi_miso=0, rx_data=0, rx_valid=0, rx_overrun=0, tx_ready=1 (buffer empty), tx_underrun=0, frame_active=0, frame_abort=0.
REQ-035 Reset asserted mid-frame abandons the frame with no abort pulse; after release the FSM waits for a fresh cs_n fall event.

Configuration
REQ-036 Macro SPI_SLAVE_TX_EN defined: TX buffer, TX shift register, spi_miso and tx_underrun operate per REQ-027..REQ-029.
REQ-037 Macro SPI_SLAVE_TX_EN undefined: TX logic omitted, spi_miso=0, tx_ready=0, tx_underrun=0 constant; tx_data/tx_valid are ignored; RX path is unchanged.

Verification
REQ-038 DATA_WIDTH=8, load tx 0xA5, frame of 8 bits with MOSI 0x3C -> rx_data=0x3C, rx_valid=1, MISO bits 1,0,1,0,0,1,0,1, no pulses.
REQ-039 Two-word frame MOSI 0x11,0x22 with rx_ready=0 -> rx_data=0x11, rx_overrun pulses once, rx_valid stays 1.
REQ-040 Frame with no tx load -> tx_underrun pulses at cs_n fall; MISO reads 0xFF.
REQ-041 cs_n rises after 5 bits -> frame_abort pulses once, rx_valid unchanged, next full frame of 0x81 -> rx_data=0x81.
REQ-042 cs_n rise edge aligned with an sclk rise (same clk cycle after sync) -> counter unchanged by that edge, FSM=IDLE.
REQ-043 rst pulsed after 3 bits, then full frame 0xC3 -> rx_data=0xC3, no frame_abort.

Source files
------------

// File: rtl/spi_slave_frame_ctrl.sv
// rtl/spi_slave_frame_ctrl.sv - SPI mode-0 slave framer with RX/TX word handshakes (optional TX path: SPI_SLAVE_TX_EN)
module spi_slave_frame_ctrl #(
    parameter int   DATA_WIDTH = 8,
    parameter logic TX_FILL    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  frame_active,
    output logic                  frame_abort
);

    localparam int              CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic sclk_s1, sclk_s2, sclk_h;
    logic cs_s1, cs_s2, cs_h;
    logic mosi_s1, mosi_s2, mosi_h;

    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_shift_d;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic in_active, bit_rise, bit_fall, word_done, word_start, abort_now;

    // Two-flop synchronizers plus a history flop per pin for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_h  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_h    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            mosi_h  <= 1'b0;
        end else begin
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            mosi_h  <= mosi_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign sclk_fall = ~sclk_s2 & sclk_h;
    assign cs_fall   = ~cs_s2 & cs_h;
    assign cs_rise   = cs_s2 & ~cs_h;

    // A chip-select release wins over any sclk event seen in the same cycle
    assign in_active  = (state_q == ACTIVE);
    assign bit_rise   = in_active & sclk_rise & ~cs_rise;
    assign bit_fall   = in_active & sclk_fall & ~cs_rise;
    assign word_done  = bit_rise & (bit_cnt == LAST);
    assign word_start = (~in_active & cs_fall) | word_done;
    assign abort_now  = in_active & cs_rise & (bit_cnt != '0);
    assign rx_shift_d = {rx_shift[DATA_WIDTH-2:0], mosi_s2};

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame state transitions: only chip-select edges move the FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame_active = in_active;

    // RX bit counting, word capture, consumer handshake and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            frame_abort <= abort_now;

            if (!in_active || cs_rise) begin
                bit_cnt <= '0;
            end else if (bit_rise) begin
                rx_shift <= rx_shift_d;
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            end

            // A completed word is dropped only if the pending one is not taken this cycle
            if (word_done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_shift_d;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    logic unused_mosi_hist;
    assign unused_mosi_hist = mosi_h;

`ifdef SPI_SLAVE_TX_EN
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  buf_full;
    logic                  skip_fall;
    logic                  miso_q;
    logic                  underrun_q;

    // TX buffer load, word-start reload of the shifter, and MSB-first shift-out
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf     <= '0;
            tx_shift   <= '0;
            buf_full   <= 1'b0;
            skip_fall  <= 1'b0;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;

            // Load only into an empty buffer, so it never collides with a consume
            if (tx_valid && !buf_full) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end

            if (word_start) begin
                // After a wrap the new MSB is already on the pin; the next fall must not shift it away
                skip_fall <= word_done;
                if (buf_full) begin
                    tx_shift <= tx_buf;
                    miso_q   <= tx_buf[DATA_WIDTH-1];
                    buf_full <= 1'b0;
                end else begin
                    tx_shift   <= {DATA_WIDTH{TX_FILL}};
                    miso_q     <= TX_FILL;
                    underrun_q <= 1'b1;
                end
            end else if (bit_fall) begin
                if (skip_fall) begin
                    skip_fall <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    miso_q   <= tx_shift[DATA_WIDTH-2];
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign tx_ready    = ~buf_full;
    assign tx_underrun = underrun_q;
`else
    logic unused_tx;
    assign unused_tx   = ^{tx_data, tx_valid, word_start, bit_fall};

    assign spi_miso    = 1'b0;
    assign tx_ready    = 1'b0;
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// tb/tb_spi_slave_frame_ctrl.sv - self-checking bench for spi_slave_frame_ctrl
module tb_spi_slave_frame_ctrl;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_underrun;
    logic       frame_active, frame_abort;

    spi_slave_frame_ctrl #(.DATA_WIDTH(8), .TX_FILL(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overrun   (rx_overrun),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_underrun  (tx_underrun),
        .frame_active (frame_active),
        .frame_abort  (frame_abort)
    );

    always #5 clk = ~clk;

`ifdef SPI_SLAVE_TX_EN
    localparam bit TX_ON = 1'b1;
`else
    localparam bit TX_ON = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ovr_cnt = 0;
    int          abt_cnt = 0;
    int          und_cnt = 0;
    int          acc_cnt = 0;
    logic [31:0] acc_sum = 0;

    // Pulse and handshake observers
    always @(posedge clk) begin
        if (!rst) begin
            if (rx_overrun)  ovr_cnt <= ovr_cnt + 1;
            if (frame_abort) abt_cnt <= abt_cnt + 1;
            if (tx_underrun) und_cnt <= und_cnt + 1;
            if (rx_valid && rx_ready) begin
                acc_cnt <= acc_cnt + 1;
                acc_sum <= acc_sum + 32'(rx_data);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    // Master side: present MOSI, sample MISO just before each rising edge
    task automatic xfer_bits(input logic [7:0] w, input int nb, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = w[7-i];
            wait_cyc(HALF);
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b1;
            wait_cyc(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic tx_load(input logic [7:0] d);
        if (TX_ON) begin
            bit done;
            done = 1'b0;
            tx_data  = d;
            tx_valid = 1'b1;
            for (int i = 0; i < 50 && !done; i++) begin
                @(posedge clk);
                if (tx_ready) done = 1'b1;
            end
            #1;
            tx_valid = 1'b0;
            chk("tx_load_handshake", 32'(done), 32'd1);
        end
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        wait_cyc(3);
        rx_ready = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        logic [7:0] mi, m1, m2, mi0, pl;
        logic [7:0] wd [3];
        int o0, a0, u0, c0, n, rdy, pre;
        logic [31:0] s0, sum;
        logic [7:0] fill_w;

        fill_w   = TX_ON ? 8'hFF : 8'h00;
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rx_ready = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);

        chk("rst_miso",         32'(spi_miso),     32'd0);
        chk("rst_rx_data",      32'(rx_data),      32'd0);
        chk("rst_rx_valid",     32'(rx_valid),     32'd0);
        chk("rst_rx_overrun",   32'(rx_overrun),   32'd0);
        chk("rst_tx_ready",     32'(tx_ready),     32'(TX_ON));
        chk("rst_tx_underrun",  32'(tx_underrun),  32'd0);
        chk("rst_frame_active", 32'(frame_active), 32'd0);
        chk("rst_frame_abort",  32'(frame_abort),  32'd0);

        // Single word with TX data preloaded, second TX word refilled mid-frame
        o0 = ovr_cnt; a0 = abt_cnt; u0 = und_cnt;
        tx_load(8'hA5);
        cs_low();
        chk("a_frame_active", 32'(frame_active), 32'd1);
        tx_load(8'h5A);
        xfer_bits(8'h3C, 8, mi);
        cs_high();
        chk("a_rx_data",  32'(rx_data),  32'h3C);
        chk("a_rx_valid", 32'(rx_valid), 32'd1);
        chk("a_miso",     32'(mi),       TX_ON ? 32'hA5 : 32'h00);
        chk("a_overrun",  32'(ovr_cnt - o0), 32'd0);
        chk("a_abort",    32'(abt_cnt - a0), 32'd0);
        chk("a_underrun", 32'(und_cnt - u0), 32'd0);
        chk("a_idle",     32'(frame_active), 32'd0);
        drain();
        chk("a_drained",  32'(rx_valid), 32'd0);

        // Two words while consumer stalls; no TX data at all
        o0 = ovr_cnt; u0 = und_cnt;
        cs_low();
        xfer_bits(8'h11, 8, m1);
        xfer_bits(8'h22, 8, m2);
        cs_high();
        chk("b_rx_data",  32'(rx_data),  32'h11);
        chk("b_rx_valid", 32'(rx_valid), 32'd1);
        chk("b_overrun",  32'(ovr_cnt - o0), 32'd1);
        chk("b_miso0",    32'(m1), 32'(fill_w));
        chk("b_miso1",    32'(m2), 32'(fill_w));
        chk("b_underrun", 32'(und_cnt - u0), TX_ON ? 32'd3 : 32'd0);
        drain();

        // Partial word abort, then a clean frame
        a0 = abt_cnt;
        cs_low();
        xfer_bits(8'hF0, 5, mi);
        cs_high();
        chk("c_abort",    32'(abt_cnt - a0), 32'd1);
        chk("c_rx_valid", 32'(rx_valid), 32'd0);
        chk("c_idle",     32'(frame_active), 32'd0);
        cs_low();
        xfer_bits(8'h81, 8, mi);
        cs_high();
        chk("c_rx_data",  32'(rx_data),  32'h81);
        chk("c_abort2",   32'(abt_cnt - a0), 32'd1);
        drain();

        // Final sclk rise arrives together with cs_n release: the bit must be discarded
        a0 = abt_cnt; o0 = ovr_cnt;
        cs_low();
        xfer_bits(8'hAB, 7, mi);
        spi_mosi = 1'b1;
        wait_cyc(HALF);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        wait_cyc(HALF);
        spi_sclk = 1'b0;
        wait_cyc(2 * HALF);
        chk("d_abort",    32'(abt_cnt - a0), 32'd1);
        chk("d_rx_valid", 32'(rx_valid), 32'd0);
        chk("d_idle",     32'(frame_active), 32'd0);
        chk("d_overrun",  32'(ovr_cnt - o0), 32'd0);

        // Reset in the middle of a frame, then a fresh frame
        a0 = abt_cnt;
        cs_low();
        xfer_bits(8'h5A, 3, mi);
        rst = 1'b1;
        wait_cyc(2);
        spi_cs_n = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        chk("e_idle_after_rst", 32'(frame_active), 32'd0);
        cs_low();
        xfer_bits(8'hC3, 8, mi);
        cs_high();
        chk("e_rx_data",  32'(rx_data),  32'hC3);
        chk("e_rx_valid", 32'(rx_valid), 32'd1);
        chk("e_abort",    32'(abt_cnt - a0), 32'd0);
        drain();

        // Randomized frames against the word-level model
        for (int f = 0; f < 6; f++) begin
            n   = int'($urandom_range(1, 3));
            rdy = int'($urandom_range(0, 1));
            pre = TX_ON ? int'($urandom_range(0, 1)) : 0;
            pl  = 8'($urandom);
            sum = 0;
            for (int k = 0; k < 3; k++) wd[k] = 8'($urandom);
            for (int k = 0; k < n; k++) sum = sum + 32'(wd[k]);
            o0 = ovr_cnt; u0 = und_cnt; c0 = acc_cnt; s0 = acc_sum;
            rx_ready = rdy[0];
            if (pre != 0) tx_load(pl);
            cs_low();
            mi0 = '0;
            for (int k = 0; k < n; k++) begin
                xfer_bits(wd[k], 8, mi);
                if (k == 0) mi0 = mi;
            end
            cs_high();
            chk("r_rx_data",  32'(rx_data),  rdy != 0 ? 32'(wd[n-1]) : 32'(wd[0]));
            chk("r_rx_valid", 32'(rx_valid), rdy != 0 ? 32'd0 : 32'd1);
            chk("r_overrun",  32'(ovr_cnt - o0), rdy != 0 ? 32'd0 : 32'(n - 1));
            chk("r_miso0",    32'(mi0), pre != 0 ? 32'(pl) : 32'(fill_w));
            chk("r_underrun", 32'(und_cnt - u0), TX_ON ? 32'(n + 1 - pre) : 32'd0);
            rx_ready = 1'b0;
            drain();
            chk("r_accepted", 32'(acc_cnt - c0), rdy != 0 ? 32'(n) : 32'd1);
            chk("r_acc_sum",  acc_sum - s0, rdy != 0 ? sum : 32'(wd[0]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
